// File: rtl/fb_dma_pkg.sv
// rtl/fb_dma_pkg.sv - shared states, constants and stride helper for the fb DMA copier
package fb_dma_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD_A = 3'd1;
  localparam logic [2:0] ST_RD_B = 3'd2;
  localparam logic [2:0] ST_WR_A = 3'd3;
  localparam logic [2:0] ST_WR_B = 3'd4;

  localparam logic [1:0] FB_EXC_NONE = 2'b00;

  // Per-byte mask bit; replicated to DW/8 by the user.
  localparam logic AWMSK_RD = 1'b0;
  localparam logic AWMSK_WR = 1'b1;

  function automatic int fb_dma_stride(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/fb_dma_agen.sv
// rtl/fb_dma_agen.sv - source/destination address and remaining-word tracking for the fb DMA copier
module fb_dma_agen
  import fb_dma_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_step_src,
  input  logic [AW-1:0]    i_src,
  input  logic [AW-1:0]    i_dst,
  input  logic [LEN_W-1:0] i_len,
  output logic [AW-1:0]    o_cur_src,
  output logic [AW-1:0]    o_cur_dst,
  output logic [AW-1:0]    o_nxt_src,
  output logic [AW-1:0]    o_nxt_dst,
  output logic             o_last
);

  localparam logic [AW-1:0] STRIDE    = AW'(fb_dma_stride(DW));
  localparam logic [AW-1:0] ADDR_MASK = ~(STRIDE - AW'(1));

  logic [AW-1:0]    r_src;
  logic [AW-1:0]    r_dst;
  logic [LEN_W-1:0] r_rem;

  // Addresses wrap silently modulo 2^AW.
  assign o_nxt_src = r_src + STRIDE;
  assign o_nxt_dst = r_dst + STRIDE;
  assign o_cur_src = r_src;
  assign o_cur_dst = r_dst;
  assign o_last    = (r_rem == LEN_W'(1));

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_src <= '0;
      r_dst <= '0;
      r_rem <= '0;
    end else if (i_load) begin
      r_src <= i_src & ADDR_MASK;
      r_dst <= i_dst & ADDR_MASK;
      r_rem <= i_len;
    end else if (i_step) begin
      r_dst <= o_nxt_dst;
      r_rem <= r_rem - LEN_W'(1);
      if (i_step_src) r_src <= o_nxt_src;
    end
  end

endmodule

// File: rtl/fb_dma_copier.sv
// rtl/fb_dma_copier.sv - single-outstanding fb bus block copier; NCPU_FB_DMA_FILL_EN adds pattern fill mode
module fb_dma_copier
  import fb_dma_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    src,
  input  logic [AW-1:0]    dst,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_exc,
  output logic             fb_AVALID,
  input  logic             fb_AREADY,
  output logic [AW-1:0]    fb_AADDR,
  output logic [DW-1:0]    fb_ADATA,
  output logic [DW/8-1:0]  fb_AWMSK,
  output logic [1:0]       fb_AEXC,
  input  logic             fb_BVALID,
  output logic             fb_BREADY,
  input  logic [DW-1:0]    fb_BDATA,
  input  logic [1:0]       fb_BEXC
`ifdef NCPU_FB_DMA_FILL_EN
  ,
  input  logic             fill,
  input  logic [DW-1:0]    pattern
`endif
);

  localparam int              BW        = DW / 8;
  localparam logic [AW-1:0]   ADDR_MASK = ~(AW'(fb_dma_stride(DW)) - AW'(1));
  localparam logic [BW-1:0]   MSK_RD    = {BW{AWMSK_RD}};
  localparam logic [BW-1:0]   MSK_WR    = {BW{AWMSK_WR}};

  logic [2:0]    r_state;
  logic          r_busy, r_done, r_err;
  logic [1:0]    r_err_exc;
  logic          r_avalid, r_bready;
  logic [AW-1:0] r_aaddr;
  logic [DW-1:0] r_adata;
  logic [BW-1:0] r_awmsk;

  logic          w_start_ok, w_b_ok, w_step;
  logic          w_fill_start, w_fill_mode;
  logic [DW-1:0] w_pattern;
  logic [AW-1:0] w_cur_src, w_cur_dst, w_nxt_src, w_nxt_dst;
  logic          w_last;

`ifdef NCPU_FB_DMA_FILL_EN
  logic r_fill;
  always_ff @(posedge clk) begin
    if (rst)             r_fill <= 1'b0;
    else if (w_start_ok) r_fill <= fill;
  end
  assign w_fill_start = fill;
  assign w_fill_mode  = r_fill;
  assign w_pattern    = pattern;
`else
  assign w_fill_start = 1'b0;
  assign w_fill_mode  = 1'b0;
  assign w_pattern    = '0;
`endif

  assign w_start_ok = (r_state == ST_IDLE) && start && (len != '0);
  assign w_b_ok     = fb_BVALID && (fb_BEXC == FB_EXC_NONE);
  assign w_step     = (r_state == ST_WR_B) && w_b_ok;

  fb_dma_agen #(.AW(AW), .DW(DW), .LEN_W(LEN_W)) u_agen (
    .clk        (clk),
    .i_rst      (rst),
    .i_load     (w_start_ok),
    .i_step     (w_step),
    .i_step_src (!w_fill_mode),
    .i_src      (src),
    .i_dst      (dst),
    .i_len      (len),
    .o_cur_src  (w_cur_src),
    .o_cur_dst  (w_cur_dst),
    .o_nxt_src  (w_nxt_src),
    .o_nxt_dst  (w_nxt_dst),
    .o_last     (w_last)
  );

  // A-channel fields only change on entry to an A state, so they are stable through stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_err_exc <= FB_EXC_NONE;
      r_avalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_aaddr   <= '0;
      r_adata   <= '0;
      r_awmsk   <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_err_exc <= FB_EXC_NONE;
            if (len == '0) begin
              r_done <= 1'b1;
            end else if (w_fill_start) begin
              r_busy   <= 1'b1;
              r_avalid <= 1'b1;
              r_aaddr  <= dst & ADDR_MASK;
              r_adata  <= w_pattern;
              r_awmsk  <= MSK_WR;
              r_state  <= ST_WR_A;
            end else begin
              r_busy   <= 1'b1;
              r_avalid <= 1'b1;
              r_aaddr  <= src & ADDR_MASK;
              r_awmsk  <= MSK_RD;
              r_state  <= ST_RD_A;
            end
          end
        end
        ST_RD_A: begin
          if (fb_AREADY) begin
            r_avalid <= 1'b0;
            r_bready <= 1'b1;
            r_state  <= ST_RD_B;
          end
        end
        ST_RD_B: begin
          if (fb_BVALID) begin
            r_bready <= 1'b0;
            if (!w_b_ok) begin
              r_err     <= 1'b1;
              r_err_exc <= fb_BEXC;
              r_busy    <= 1'b0;
              r_state   <= ST_IDLE;
            end else begin
              r_adata  <= fb_BDATA;
              r_aaddr  <= w_cur_dst;
              r_awmsk  <= MSK_WR;
              r_avalid <= 1'b1;
              r_state  <= ST_WR_A;
            end
          end
        end
        ST_WR_A: begin
          if (fb_AREADY) begin
            r_avalid <= 1'b0;
            r_bready <= 1'b1;
            r_state  <= ST_WR_B;
          end
        end
        ST_WR_B: begin
          if (fb_BVALID) begin
            r_bready <= 1'b0;
            if (!w_b_ok) begin
              r_err     <= 1'b1;
              r_err_exc <= fb_BEXC;
              r_busy    <= 1'b0;
              r_state   <= ST_IDLE;
            end else if (w_last) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else if (w_fill_mode) begin
              r_aaddr  <= w_nxt_dst;
              r_avalid <= 1'b1;
              r_state  <= ST_WR_A;
            end else begin
              r_aaddr  <= w_nxt_src;
              r_awmsk  <= MSK_RD;
              r_avalid <= 1'b1;
              r_state  <= ST_RD_A;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign err_exc   = r_err_exc;
  assign fb_AVALID = r_avalid;
  assign fb_AADDR  = r_aaddr;
  assign fb_ADATA  = r_adata;
  assign fb_AWMSK  = r_awmsk;
  assign fb_AEXC   = FB_EXC_NONE;
  assign fb_BREADY = r_bready;

endmodule

// File: tb/tb_fb_dma_copier.sv
// tb/tb_fb_dma_copier.sv - scoreboard bench for fb_dma_copier with an SRAM-like responder
module tb_fb_dma_copier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src = '0, dst = '0;
  logic [15:0] len = '0;
  logic        busy, done, err;
  logic [1:0]  err_exc;
  logic        fb_AVALID, fb_BREADY;
  logic        fb_AREADY = 1'b0, fb_BVALID = 1'b0;
  logic [31:0] fb_AADDR, fb_ADATA;
  logic [3:0]  fb_AWMSK;
  logic [1:0]  fb_AEXC;
  logic [31:0] fb_BDATA = '0;
  logic [1:0]  fb_BEXC = '0;
`ifdef NCPU_FB_DMA_FILL_EN
  logic        fill = 1'b0;
  logic [31:0] pattern = '0;
`endif

  fb_dma_copier #(.AW(32), .DW(32), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .err(err), .err_exc(err_exc),
    .fb_AVALID(fb_AVALID), .fb_AREADY(fb_AREADY), .fb_AADDR(fb_AADDR),
    .fb_ADATA(fb_ADATA), .fb_AWMSK(fb_AWMSK), .fb_AEXC(fb_AEXC),
    .fb_BVALID(fb_BVALID), .fb_BREADY(fb_BREADY), .fb_BDATA(fb_BDATA), .fb_BEXC(fb_BEXC)
`ifdef NCPU_FB_DMA_FILL_EN
    , .fill(fill), .pattern(pattern)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [31:0] mem [0:255];
  logic [63:0] sb [$];
  logic [31:0] rd_log [$];
  int delay = 0, inj_rd = 0;
  int a_hs = 0, b_hs = 0, wr_cnt = 0, rd_cnt = 0;
  bit pend = 0, p_rd = 0;
  int p_rd_no = 0, a_cnt = 0, b_cnt = 0;
  logic [31:0] p_addr;
  bit stall_prev = 0;
  logic [36:0] saved_ctl;
  logic [31:0] saved_data;

  function automatic logic [7:0] idx(input logic [31:0] a);
    return a[9:2];
  endfunction

  // Bus monitor / memory: sees pre-edge values of DUT outputs.
  always @(posedge clk) begin
    if (rst) begin
      pend = 0;
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        chk("a_stable_ctl", {fb_AVALID, fb_AWMSK, fb_AADDR}, saved_ctl);
        chk("a_stable_data", fb_ADATA, saved_data);
      end
      stall_prev = fb_AVALID && !fb_AREADY;
      saved_ctl  = {fb_AVALID, fb_AWMSK, fb_AADDR};
      saved_data = fb_ADATA;
      if (fb_AVALID && fb_AREADY) begin
        a_hs++;
        pend = 1;
        p_addr = fb_AADDR;
        p_rd = (fb_AWMSK == 4'h0);
        if (p_rd) begin
          rd_cnt++;
          p_rd_no = rd_cnt;
          rd_log.push_back(fb_AADDR);
        end else begin
          wr_cnt++;
          mem[idx(fb_AADDR)] = fb_ADATA;
          if (sb.size() == 0) chk("sb_extra_write", 64'(fb_AADDR), 64'hFFFF_FFFF_FFFF_FFFF);
          else begin
            logic [63:0] e;
            e = sb.pop_front();
            chk("sb_waddr", 64'(fb_AADDR), 64'(e[63:32]));
            chk("sb_wdata", 64'(fb_ADATA), 64'(e[31:0]));
          end
        end
      end
      if (fb_BVALID && fb_BREADY) begin
        b_hs++;
        pend = 0;
      end
    end
  end

  // Responder: decides handshake inputs for the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      fb_AREADY = 0; fb_BVALID = 0; fb_BEXC = 0; a_cnt = 0; b_cnt = 0;
    end else begin
      if (fb_AVALID && !pend) begin
        if (a_cnt >= delay) fb_AREADY = 1;
        else begin fb_AREADY = 0; a_cnt++; end
      end else begin
        fb_AREADY = 0; a_cnt = 0;
      end
      if (pend) begin
        if (b_cnt >= delay) begin
          fb_BVALID = 1;
          fb_BDATA  = p_rd ? mem[idx(p_addr)] : 32'h0;
          fb_BEXC   = (p_rd && p_rd_no == inj_rd) ? 2'b01 : 2'b00;
        end else begin
          fb_BVALID = 0; b_cnt++;
        end
      end else begin
        fb_BVALID = 0; fb_BEXC = 0; b_cnt = 0;
      end
    end
  end

  task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int nw);
    for (int i = 0; i < nw; i++) begin
      logic [31:0] sa, da;
      sa = s + 32'(4 * i);
      da = d + 32'(4 * i);
      sb.push_back({da, mem[idx(sa)]});
    end
  endtask

  // n counts rising edges after the one that sampled start.
  task automatic do_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                         input int mid_at, output int done_at, output int busy_n,
                         output int done_n, output int err_n, output int av_n);
    int fin;
    fin = -1; done_at = -1; busy_n = 0; done_n = 0; err_n = 0; av_n = 0;
    @(negedge clk);
    start = 1; src = s; dst = d; len = l;
    @(negedge clk);
    start = 0;
    for (int n = 0; n < 600; n++) begin
      if (n == mid_at) begin
        start = 1; src = 32'h3C0; dst = 32'h3E0; len = 16'd5;
      end else start = 0;
      if (busy) busy_n++;
      if (fb_AVALID) av_n++;
      if (done) begin done_n++; if (done_at < 0) done_at = n; end
      if (err) err_n++;
      if ((done || err) && fin < 0) fin = n;
      if (fin >= 0 && n >= fin + 3) break;
      @(negedge clk);
    end
    start = 0;
    if (fin < 0) chk("xfer_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    int dat, bn, dn, en, av, a0, b0, w0, r0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_err_exc", err_exc, 0);
    chk("rst_avalid", fb_AVALID, 0);
    chk("rst_bready", fb_BREADY, 0);
    chk("rst_aaddr", fb_AADDR, 0);
    chk("rst_adata", fb_ADATA, 0);
    chk("rst_awmsk", fb_AWMSK, 0);
    chk("aexc", fb_AEXC, 0);
    rst = 0;

    // Zero-wait copy of four words
    for (int i = 0; i < 4; i++) mem[idx(32'h100) + i] = 32'hA0 + 32'(i);
    push_copy(32'h100, 32'h200, 4);
    do_xfer(32'h100, 32'h200, 16'd4, -1, dat, bn, dn, en, av);
    chk("t1_done_at", 64'(dat), 64'd16);
    chk("t1_busy_cycles", 64'(bn), 64'd16);
    chk("t1_done_pulses", 64'(dn), 64'd1);
    chk("t1_err", 64'(en), 64'd0);
    chk("t1_dst3", mem[idx(32'h20C)], 32'hA3);
    chk("t1_sb_empty", 64'(sb.size()), 64'd0);

    // Stalling responder
    delay = 2;
    for (int i = 0; i < 3; i++) mem[idx(32'h10) + i] = $urandom;
    a0 = a_hs; b0 = b_hs;
    push_copy(32'h10, 32'h300, 3);
    do_xfer(32'h10, 32'h300, 16'd3, -1, dat, bn, dn, en, av);
    chk("t2_a_hs", 64'(a_hs - a0), 64'd6);
    chk("t2_b_hs", 64'(b_hs - b0), 64'd6);
    chk("t2_done_pulses", 64'(dn), 64'd1);
    chk("t2_sb_empty", 64'(sb.size()), 64'd0);
    delay = 0;

    // Zero-length request
    do_xfer(32'h100, 32'h200, 16'd0, -1, dat, bn, dn, en, av);
    chk("t3_done_at", 64'(dat), 64'd0);
    chk("t3_done_pulses", 64'(dn), 64'd1);
    chk("t3_avalid_cycles", 64'(av), 64'd0);
    chk("t3_busy", 64'(bn), 64'd0);

    // Fault on the second read response
    for (int i = 0; i < 4; i++) begin
      mem[idx(32'h100) + i] = 32'hB0 + 32'(i);
      mem[idx(32'h200) + i] = 32'h5A5A_0000 + 32'(i);
    end
    inj_rd = rd_cnt + 2;
    w0 = wr_cnt; r0 = rd_cnt;
    push_copy(32'h100, 32'h200, 1);
    do_xfer(32'h100, 32'h200, 16'd4, -1, dat, bn, dn, en, av);
    chk("t4_err_pulses", 64'(en), 64'd1);
    chk("t4_done_pulses", 64'(dn), 64'd0);
    chk("t4_err_exc", err_exc, 2'b01);
    chk("t4_writes", 64'(wr_cnt - w0), 64'd1);
    chk("t4_reads", 64'(rd_cnt - r0), 64'd2);
    chk("t4_dst1_untouched", mem[idx(32'h204)], 32'h5A5A_0001);
    chk("t4_sb_empty", 64'(sb.size()), 64'd0);
    inj_rd = 0;

    // Address wrap plus an ignored start while busy
    mem[255] = 32'hC0FF_EE01;
    mem[0]   = 32'hC0FF_EE02;
    rd_log.delete();
    push_copy(32'hFFFF_FFFC, 32'h40, 2);
    do_xfer(32'hFFFF_FFFC, 32'h40, 16'd2, 3, dat, bn, dn, en, av);
    chk("t5_reads", 64'(rd_log.size()), 64'd2);
    if (rd_log.size() == 2) chk("t5_wrap_addr", rd_log[1], 32'h0);
    chk("t5_done_pulses", 64'(dn), 64'd1);
    chk("t5_busy_cycles", 64'(bn), 64'd8);
    chk("t5_sb_empty", 64'(sb.size()), 64'd0);

    // Reset while a write command is pending
    @(negedge clk);
    start = 1; src = 32'h100; dst = 32'h240; len = 16'd2;
    @(negedge clk);
    start = 0;
    begin
      int k;
      for (k = 0; k < 50; k++) begin
        if (fb_AVALID && fb_AWMSK != 4'h0) break;
        @(negedge clk);
      end
      chk("t6_reach_wr_a", 64'(k < 50), 64'd1);
    end
    rst = 1;
    @(negedge clk);
    chk("t6_avalid", fb_AVALID, 0);
    chk("t6_bready", fb_BREADY, 0);
    chk("t6_busy", busy, 0);
    rst = 0;
    sb.delete();
    mem[idx(32'h100)] = 32'h7700_0001;
    mem[idx(32'h104)] = 32'h7700_0002;
    push_copy(32'h100, 32'h240, 2);
    do_xfer(32'h100, 32'h240, 16'd2, -1, dat, bn, dn, en, av);
    chk("t6_done_pulses", 64'(dn), 64'd1);
    chk("t6_sb_empty", 64'(sb.size()), 64'd0);

`ifdef NCPU_FB_DMA_FILL_EN
    fill = 1; pattern = 32'hDEAD_BEEF;
    r0 = rd_cnt; w0 = wr_cnt;
    for (int i = 0; i < 3; i++) sb.push_back({32'h380 + 32'(4 * i), 32'hDEAD_BEEF});
    do_xfer(32'h100, 32'h380, 16'd3, -1, dat, bn, dn, en, av);
    fill = 0;
    chk("t7_reads", 64'(rd_cnt - r0), 64'd0);
    chk("t7_writes", 64'(wr_cnt - w0), 64'd3);
    chk("t7_busy_cycles", 64'(bn), 64'd6);
    chk("t7_done_pulses", 64'(dn), 64'd1);
    chk("t7_sb_empty", 64'(sb.size()), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fb_dma_copier.md
Name: fb_dma_copier

Overview:
- Initiator on the fb handshake command bus, driving the A channel and consuming the B channel.
- Copies LEN consecutive words from SRC to DST using single-outstanding read/write command pairs.
- Sits beside the CPU as a third master on the fb arbiter; its counterpart is the SRAM responder.
- Exists to offload block moves and to act as a bus-protocol exerciser in system benches.

Parameters:
- AW, 32, address width (matches NCPU_AW).
- DW, 32, data width (matches NCPU_DW); address stride per word = DW/8.
- LEN_W, 16, width of the word-count field.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; latches src/dst/len when idle
- src  in  AW  source byte address; low log2(DW/8) bits forced to 0
- dst  in  AW  destination byte address; low bits forced to 0
- len  in  LEN_W  number of words to copy
- busy  out  1  high from accepted start until done/err
- done  out  1  one-cycle pulse on successful completion
- err  out  1  one-cycle pulse on abort
- err_exc  out  2  BEXC of the failing beat, held until next accepted start
- fb_AVALID  out  1  command valid
- fb_AREADY  in  1  command accepted
- fb_AADDR  out  AW  command address
- fb_ADATA  out  DW  write data
- fb_AWMSK  out  DW/8  byte-write mask; all-ones = write, zero = read
- fb_AEXC  out  2  always 2'b00
- fb_BVALID  in  1  response valid
- fb_BREADY  out  1  response accept
- fb_BDATA  in  DW  read data
- fb_BEXC  in  2  response exception; nonzero = fault

Behaviour:
- Reset values: busy=0, done=0, err=0, err_exc=0, fb_AVALID=0, fb_BREADY=0, fb_AADDR=0, fb_ADATA=0, fb_AWMSK=0. FSM returns to IDLE.
- Every A command yields exactly one B beat. At most one command is outstanding.
- FSM states: IDLE, RD_A, RD_B, WR_A, WR_B.
- IDLE:
  - start with len≠0 → RD_A; src, dst and len are latched.
  - start with len=0 → done pulses the next cycle; no bus traffic; stays IDLE.
- RD_A:
  - fb_AVALID=1, AADDR=cur_src, AWMSK=0.
  - On AVALID&&AREADY → RD_B.
- RD_B:
  - fb_BREADY=1.
  - On BVALID: if BEXC≠0 → abort; else latch BDATA into the data register → WR_A.
- WR_A:
  - fb_AVALID=1, AADDR=cur_dst, ADATA=data register, AWMSK all-ones.
  - On handshake → WR_B.
- WR_B:
  - fb_BREADY=1.
  - On BVALID: if BEXC≠0 → abort.
  - Otherwise cur_src and cur_dst each advance by DW/8, modulo 2^AW (wrap-around is silent), and remaining decrements.
  - If remaining was 1 → done pulse, IDLE; else → RD_A.
- A-channel stability: AVALID, AADDR, ADATA and AWMSK are registered and held stable until AREADY is sampled high. AVALID is never withdrawn before the handshake.
- fb_BREADY is high only in the RD_B and WR_B states.
- Abort: err pulses for 1 cycle, err_exc=BEXC, busy drops, FSM goes to IDLE. Remaining words are not transferred.
- start while busy is ignored and its inputs are not latched.
- Timing: done/err assert the cycle after the final B handshake; busy deasserts in the same cycle.
- Minimum cost per word is 4 cycles with zero-wait responder (A, B, A, B).
- AREADY and BVALID asserted in the same cycle: only the signal relevant to the current state is honoured.
- rst mid-transfer: immediate return to IDLE with outputs at reset values. The outstanding B beat is never accepted (BREADY=0); the system resets the responder together with this block.

Optional Feature:
- Macro: NCPU_FB_DMA_FILL_EN.
- When defined, adds input fill (1 bit, sampled with start) and input pattern (DW bits, latched on start).
- With fill=1, IDLE → WR_A directly and the RD states are skipped. Each word writes the latched pattern to dst, and only dst advances. Cost is 2 cycles per word minimum.
- When undefined, these ports do not exist and only copy mode is implemented.

Decomposition:
- Shared package fb_dma_pkg:
  - FSM state enum (IDLE, RD_A, RD_B, WR_A, WR_B).
  - Constants FB_EXC_NONE=2'b00, AWMSK_RD=0, AWMSK_WR=all-ones.
  - Stride function DW/8.
- Natural sub-module fb_dma_agen: holds cur_src, cur_dst and remaining. It takes load and step strobes and outputs last (remaining==1).

Test Plan:
- Zero-wait SRAM, src=0x100, dst=0x200, len=4, memory words 0xA0..0xA3 → dst words equal 0xA0..0xA3; done is one pulse at cycle 16 after start; busy is high for 16 cycles.
- Responder with DELAY=2 on AREADY and BVALID, len=3 → AVALID/AADDR/ADATA are held constant during every stall; exactly 6 A handshakes and 6 B handshakes occur.
- len=0 start → done is high exactly 1 cycle later; fb_AVALID stays 0 throughout.
- BEXC=2'b01 injected on the second read response, len=4 → err pulses once, err_exc=01, only 1 write is issued, dst+4 is unmodified.
- src=0xFFFFFFFC, len=2 → second read address is 0x00000000 (wrap); start pulsed again mid-transfer is ignored.
- rst asserted in WR_A → next cycle AVALID=0, BREADY=0, busy=0; a fresh start copies correctly. With NCPU_FB_DMA_FILL_EN, fill=1, pattern=0xDEADBEEF, len=3 → 3 writes of the pattern and no reads.
